// File: rtl/csi_packet_ctrl_if.sv
// Aligner-side inputs and packet/payload outputs of the CSI-2 packet controller.
interface csi_packet_ctrl_if;
  logic        dl0_rxvalidhs;
  logic        dl1_rxvalidhs;
  logic [15:0] word_in;
  logic        word_valid;
  logic        align_resetn;
  logic        hdr_valid;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic        short_pkt;
  logic [15:0] pay_data;
  logic        pay_valid;
  logic [1:0]  pay_keep;
  logic        pay_last;
  logic        frame_active;
  logic [15:0] line_count;
  logic        ecc_err;
  logic        sync_err;
  logic        trunc_err;

  modport master (
    output dl0_rxvalidhs, dl1_rxvalidhs, word_in, word_valid,
    input  align_resetn, hdr_valid, pkt_vc, pkt_dt, pkt_wc, short_pkt,
    input  pay_data, pay_valid, pay_keep, pay_last,
    input  frame_active, line_count, ecc_err, sync_err, trunc_err
  );

  modport slave (
    input  dl0_rxvalidhs, dl1_rxvalidhs, word_in, word_valid,
    output align_resetn, hdr_valid, pkt_vc, pkt_dt, pkt_wc, short_pkt,
    output pay_data, pay_valid, pay_keep, pay_last,
    output frame_active, line_count, ecc_err, sync_err, trunc_err
  );
endinterface

// File: rtl/csi_packet_ctrl.sv
// CSI-2 2-lane packet controller: header parse/ECC, payload streaming with keep/last,
// frame/line tracking and aligner reset sequencing between HS bursts.
module csi_packet_ctrl #(
  parameter int unsigned SYNC_TIMEOUT      = 255,
  parameter int unsigned FLUSH_IDLE_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  csi_packet_ctrl_if.slave bus
);

  localparam int unsigned TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned FL_W = $clog2(FLUSH_IDLE_CYCLES + 1);
  localparam logic [5:0]  DT_FS       = 6'h00;
  localparam logic [5:0]  DT_FE       = 6'h01;
  localparam logic [5:0]  DT_LONG_MIN = 6'h10;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR2, ST_PAYLOAD, ST_FLUSH} state_t;

  // Each ECC parity bit covers a fixed subset of the 24-bit {WC_hi, WC_lo, DI} vector.
  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    hdr_ecc = {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
               ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [FL_W-1:0] fl_cnt_q, fl_cnt_d, fl_cnt_inc;
  logic [7:0]      di_q, di_d, wc_lo_q, wc_lo_d;
  logic [15:0]     rem_q, rem_d;
  logic            align_resetn_q, align_resetn_d;
  logic            hdr_valid_q, hdr_valid_d;
  logic [1:0]      pkt_vc_q, pkt_vc_d;
  logic [5:0]      pkt_dt_q, pkt_dt_d;
  logic [15:0]     pkt_wc_q, pkt_wc_d;
  logic            short_pkt_q, short_pkt_d;
  logic [15:0]     pay_data_q, pay_data_d;
  logic            pay_valid_q, pay_valid_d;
  logic [1:0]      pay_keep_q, pay_keep_d;
  logic            pay_last_q, pay_last_d;
  logic            frame_active_q, frame_active_d;
  logic [15:0]     line_count_q, line_count_d;
  logic            ecc_err_q, ecc_err_d, sync_err_q, sync_err_d, trunc_err_q, trunc_err_d;

  logic            any_hs, both_hs, ecc_ok;
  logic [15:0]     hdr_wc;

  assign any_hs     = bus.dl0_rxvalidhs | bus.dl1_rxvalidhs;
  assign both_hs    = bus.dl0_rxvalidhs & bus.dl1_rxvalidhs;
  assign to_cnt_inc = to_cnt_q + TO_W'(1);
  assign fl_cnt_inc = fl_cnt_q + FL_W'(1);
  assign hdr_wc     = {bus.word_in[15:8], wc_lo_q};
  assign ecc_ok     = (hdr_ecc({hdr_wc, di_q}) == bus.word_in[5:0]);

  always_comb begin
    state_d        = state_q;
    to_cnt_d       = to_cnt_q;
    fl_cnt_d       = fl_cnt_q;
    di_d           = di_q;
    wc_lo_d        = wc_lo_q;
    rem_d          = rem_q;
    align_resetn_d = align_resetn_q;
    hdr_valid_d    = 1'b0;
    pkt_vc_d       = pkt_vc_q;
    pkt_dt_d       = pkt_dt_q;
    pkt_wc_d       = pkt_wc_q;
    short_pkt_d    = short_pkt_q;
    pay_data_d     = pay_data_q;
    pay_valid_d    = 1'b0;
    pay_keep_d     = 2'b00;
    pay_last_d     = 1'b0;
    frame_active_d = frame_active_q;
    line_count_d   = line_count_q;
    ecc_err_d      = 1'b0;
    sync_err_d     = 1'b0;
    trunc_err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.word_valid) begin
          di_d     = bus.word_in[15:8];
          wc_lo_d  = bus.word_in[7:0];
          to_cnt_d = '0;
          state_d  = ST_HDR2;
        end else if (any_hs) begin
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == TO_W'(SYNC_TIMEOUT)) begin
            sync_err_d = 1'b1;
            state_d    = ST_FLUSH;
          end
        end else begin
          to_cnt_d = '0;
        end
      end

      ST_HDR2: begin
        if (!ecc_ok) begin
          ecc_err_d = 1'b1;
          state_d   = ST_FLUSH;
        end else begin
          hdr_valid_d = 1'b1;
          pkt_vc_d    = di_q[7:6];
          pkt_dt_d    = di_q[5:0];
          pkt_wc_d    = hdr_wc;
          short_pkt_d = (di_q[5:0] < DT_LONG_MIN);
          state_d     = ST_FLUSH;
          if (di_q[5:0] == DT_FS) begin
            frame_active_d = 1'b1;
            line_count_d   = '0;
          end else if (di_q[5:0] == DT_FE) begin
            frame_active_d = 1'b0;
          end else if (di_q[5:0] >= DT_LONG_MIN && hdr_wc != '0) begin
            rem_d   = hdr_wc;
            state_d = ST_PAYLOAD;
          end
        end
      end

      // A lane dropping before the final word aborts the packet without emitting that word.
      ST_PAYLOAD: begin
        if (!both_hs) begin
          trunc_err_d = 1'b1;
          state_d     = ST_FLUSH;
        end else if (bus.word_valid) begin
          pay_valid_d = 1'b1;
          pay_data_d  = bus.word_in;
          if (rem_q >= 16'd3) begin
            pay_keep_d = 2'b11;
            rem_d      = rem_q - 16'd2;
          end else begin
            pay_keep_d   = (rem_q == 16'd2) ? 2'b11 : 2'b10;
            pay_last_d   = 1'b1;
            line_count_d = line_count_q + 16'd1;
            state_d      = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (any_hs) begin
          fl_cnt_d = '0;
        end else if (fl_cnt_inc == FL_W'(FLUSH_IDLE_CYCLES)) begin
          fl_cnt_d       = '0;
          align_resetn_d = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          fl_cnt_d = fl_cnt_inc;
        end
      end

      default: state_d = ST_FLUSH;
    endcase

    // Entering FLUSH holds the aligner in reset and restarts idle qualification.
    if (state_d == ST_FLUSH && state_q != ST_FLUSH) begin
      align_resetn_d = 1'b0;
      fl_cnt_d       = '0;
      to_cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_FLUSH;
      to_cnt_q       <= '0;
      fl_cnt_q       <= '0;
      di_q           <= '0;
      wc_lo_q        <= '0;
      rem_q          <= '0;
      align_resetn_q <= 1'b0;
      hdr_valid_q    <= 1'b0;
      pkt_vc_q       <= '0;
      pkt_dt_q       <= '0;
      pkt_wc_q       <= '0;
      short_pkt_q    <= 1'b0;
      pay_data_q     <= '0;
      pay_valid_q    <= 1'b0;
      pay_keep_q     <= '0;
      pay_last_q     <= 1'b0;
      frame_active_q <= 1'b0;
      line_count_q   <= '0;
      ecc_err_q      <= 1'b0;
      sync_err_q     <= 1'b0;
      trunc_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      to_cnt_q       <= to_cnt_d;
      fl_cnt_q       <= fl_cnt_d;
      di_q           <= di_d;
      wc_lo_q        <= wc_lo_d;
      rem_q          <= rem_d;
      align_resetn_q <= align_resetn_d;
      hdr_valid_q    <= hdr_valid_d;
      pkt_vc_q       <= pkt_vc_d;
      pkt_dt_q       <= pkt_dt_d;
      pkt_wc_q       <= pkt_wc_d;
      short_pkt_q    <= short_pkt_d;
      pay_data_q     <= pay_data_d;
      pay_valid_q    <= pay_valid_d;
      pay_keep_q     <= pay_keep_d;
      pay_last_q     <= pay_last_d;
      frame_active_q <= frame_active_d;
      line_count_q   <= line_count_d;
      ecc_err_q      <= ecc_err_d;
      sync_err_q     <= sync_err_d;
      trunc_err_q    <= trunc_err_d;
    end
  end

  assign bus.align_resetn = align_resetn_q;
  assign bus.hdr_valid    = hdr_valid_q;
  assign bus.pkt_vc       = pkt_vc_q;
  assign bus.pkt_dt       = pkt_dt_q;
  assign bus.pkt_wc       = pkt_wc_q;
  assign bus.short_pkt    = short_pkt_q;
  assign bus.pay_data     = pay_data_q;
  assign bus.pay_valid    = pay_valid_q;
  assign bus.pay_keep     = pay_keep_q;
  assign bus.pay_last     = pay_last_q;
  assign bus.frame_active = frame_active_q;
  assign bus.line_count   = line_count_q;
  assign bus.ecc_err      = ecc_err_q;
  assign bus.sync_err     = sync_err_q;
  assign bus.trunc_err    = trunc_err_q;

endmodule

// File: tb/tb_csi_packet_ctrl.sv
// Randomized bench for csi_packet_ctrl: bursts are scored against a packet-level model
// built from the CSI-2 header/payload rules, plus directed timing scenarios.
module tb_csi_packet_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  csi_packet_ctrl_if bus();

  csi_packet_ctrl #(.SYNC_TIMEOUT(255), .FLUSH_IDLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; logic sh; } hdr_ev_t;
  typedef struct { int cyc; logic [15:0] data; logic [1:0] keep; logic last; } pay_ev_t;

  hdr_ev_t     hdr_q[$];
  pay_ev_t     pay_q[$];
  int          ecc_q[$], sync_q[$], trunc_q[$];
  int          idle_viol = 0;
  logic [15:0] burst_w[$];
  int          e0;

  // Packet-level reference state
  logic        m_frame = 1'b0;
  logic [15:0] m_line = '0;
  logic [1:0]  m_vc = '0;
  logic [5:0]  m_dt = '0;
  logic [15:0] m_wc = '0;
  logic        m_short = 1'b0;

  // Syndrome column of each data bit in the CSI-2 header ECC.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 24; i++) if (d[i]) s = s ^ ECC_COL[i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.hdr_valid)
        hdr_q.push_back('{cyc, bus.pkt_vc, bus.pkt_dt, bus.pkt_wc, bus.short_pkt});
      if (bus.pay_valid)
        pay_q.push_back('{cyc, bus.pay_data, bus.pay_keep, bus.pay_last});
      else if (bus.pay_keep != 2'b00 || bus.pay_last)
        idle_viol++;
      if (bus.ecc_err)   ecc_q.push_back(cyc);
      if (bus.sync_err)  sync_q.push_back(cyc);
      if (bus.trunc_err) trunc_q.push_back(cyc);
    end
  end

  task automatic clear_events();
    hdr_q.delete(); pay_q.delete(); ecc_q.delete(); sync_q.delete(); trunc_q.delete();
  endtask

  task automatic drive_idle();
    bus.dl0_rxvalidhs = 1'b0;
    bus.dl1_rxvalidhs = 1'b0;
    bus.word_valid    = 1'b0;
    bus.word_in       = '0;
  endtask

  task automatic make_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input logic [7:0] flip);
    logic [7:0] di, ecc;
    di  = {vc, dt};
    ecc = {2'b00, ref_ecc({wc, di})} ^ flip;
    burst_w.delete();
    burst_w.push_back({di, wc[7:0]});
    burst_w.push_back({wc[15:8], ecc});
  endtask

  // Sends the first n_sent words of burst_w with both lanes HS-valid, then idles the lanes
  // and waits (bounded) for the aligner to be released again.
  task automatic run_burst(input int n_sent);
    int   k;
    logic saw_low;
    clear_events();
    for (int i = 0; i < n_sent; i++) begin
      bus.dl0_rxvalidhs = 1'b1;
      bus.dl1_rxvalidhs = 1'b1;
      bus.word_valid    = 1'b1;
      bus.word_in       = burst_w[i];
      if (i == 0) e0 = cyc + 1;
      @(negedge clk);
    end
    drive_idle();
    k = 0;
    while (bus.align_resetn && k < 10) begin @(negedge clk); k++; end
    saw_low = !bus.align_resetn;
    while (!bus.align_resetn && k < 60) begin @(negedge clk); k++; end
    chk("flush_entered", 32'(saw_low), 32'd1);
    chk("idle_return", 32'(bus.align_resetn), 32'd1);
  endtask

  task automatic expect_burst(input int n_sent);
    logic [7:0]  di;
    logic [15:0] wc;
    logic        ok, trunc;
    int          nw, n_emit;
    di     = burst_w[0][15:8];
    wc     = {burst_w[1][15:8], burst_w[0][7:0]};
    ok     = (ref_ecc({wc, di}) == burst_w[1][5:0]);
    n_emit = 0;
    trunc  = 1'b0;
    nw     = 0;
    chk("ecc_cnt", 32'(ecc_q.size()), ok ? 32'd0 : 32'd1);
    if (!ok && ecc_q.size() > 0) chk("ecc_at", 32'(ecc_q[0] - e0), 32'd1);
    chk("hdr_cnt", 32'(hdr_q.size()), ok ? 32'd1 : 32'd0);
    if (ok) begin
      m_vc = di[7:6]; m_dt = di[5:0]; m_wc = wc; m_short = (di[5:0] < 6'h10);
      if (di[5:0] == 6'h00) begin m_frame = 1'b1; m_line = '0; end
      else if (di[5:0] == 6'h01) m_frame = 1'b0;
      if (!m_short && wc != 16'd0) begin
        nw     = (int'(wc) + 1) / 2;
        trunc  = (n_sent - 2) < nw;
        n_emit = trunc ? (n_sent - 2) : nw;
        if (!trunc) m_line = m_line + 16'd1;
      end
      if (hdr_q.size() > 0) begin
        chk("hdr_at", 32'(hdr_q[0].cyc - e0), 32'd1);
        chk("hdr_vc", 32'(hdr_q[0].vc), 32'(m_vc));
        chk("hdr_dt", 32'(hdr_q[0].dt), 32'(m_dt));
        chk("hdr_wc", 32'(hdr_q[0].wc), 32'(m_wc));
        chk("hdr_short", 32'(hdr_q[0].sh), 32'(m_short));
      end
    end
    chk("pay_cnt", 32'(pay_q.size()), 32'(n_emit));
    for (int j = 0; j < n_emit && j < pay_q.size(); j++) begin
      chk("pay_at", 32'(pay_q[j].cyc - e0), 32'(2 + j));
      chk("pay_data", 32'(pay_q[j].data), 32'(burst_w[2 + j]));
      chk("pay_keep", 32'(pay_q[j].keep), (j == nw - 1 && wc[0]) ? 32'd2 : 32'd3);
      chk("pay_last", 32'(pay_q[j].last), (j == nw - 1) ? 32'd1 : 32'd0);
    end
    chk("trunc_cnt", 32'(trunc_q.size()), trunc ? 32'd1 : 32'd0);
    if (trunc && trunc_q.size() > 0) chk("trunc_at", 32'(trunc_q[0] - e0), 32'(n_sent));
    chk("sync_cnt", 32'(sync_q.size()), 32'd0);
    chk("frame_active", 32'(bus.frame_active), 32'(m_frame));
    chk("line_count", 32'(bus.line_count), 32'(m_line));
    chk("lvl_dt", 32'(bus.pkt_dt), 32'(m_dt));
    chk("lvl_wc", 32'(bus.pkt_wc), 32'(m_wc));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          first, r, nw, n_sent;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  flip;

    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    chk("rst_align_resetn", 32'(bus.align_resetn), 32'd0);
    chk("rst_hdr_valid", 32'(bus.hdr_valid), 32'd0);
    chk("rst_pay_valid", 32'(bus.pay_valid), 32'd0);
    chk("rst_frame", 32'(bus.frame_active), 32'd0);
    chk("rst_line", 32'(bus.line_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_arn_1", 32'(bus.align_resetn), 32'd0);
    @(negedge clk);
    chk("rel_arn_2", 32'(bus.align_resetn), 32'd1);

    // Frame start short packet
    make_hdr(2'd0, 6'h00, 16'h0001, 8'h00);
    run_burst(2);
    expect_burst(2);

    // RAW8 long packet, odd WC
    make_hdr(2'd0, 6'h2A, 16'd5, 8'h00);
    burst_w.push_back(16'hAABB); burst_w.push_back(16'hCCDD); burst_w.push_back(16'hEEC0);
    burst_w.push_back(16'h5A00);
    run_burst(burst_w.size());
    expect_burst(burst_w.size());

    // Same header with a corrupted ECC bit
    make_hdr(2'd0, 6'h2A, 16'd5, 8'h04);
    burst_w.push_back(16'hAABB); burst_w.push_back(16'hCCDD); burst_w.push_back(16'hEEC0);
    run_burst(burst_w.size());
    expect_burst(burst_w.size());

    // Sync timeout: lane 0 HS-valid with no aligned words
    clear_events();
    bus.dl0_rxvalidhs = 1'b1;
    first = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.sync_err && first < 0) first = k;
    end
    chk("sync_at", 32'(first), 32'd255);
    chk("sync_pulses", 32'(sync_q.size()), 32'd1);
    chk("sync_arn_held", 32'(bus.align_resetn), 32'd0);
    bus.dl0_rxvalidhs = 1'b0;
    @(negedge clk);
    chk("sync_arn_1", 32'(bus.align_resetn), 32'd0);
    @(negedge clk);
    chk("sync_arn_2", 32'(bus.align_resetn), 32'd1);

    // WC=8 packet truncated after two payload words
    make_hdr(2'd1, 6'h2B, 16'd8, 8'h00);
    for (int j = 0; j < 5; j++) burst_w.push_back(16'h1100 + 16'(j));
    run_burst(4);
    expect_burst(4);

    // Randomized bursts
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        dt = 6'(r);
        wc = 16'($urandom);
      end else if (r < 3) begin
        dt = 6'($urandom_range(2, 15));
        wc = 16'($urandom);
      end else begin
        dt = 6'($urandom_range(16, 63));
        wc = 16'($urandom_range(0, 20));
      end
      flip = 8'h00;
      case ($urandom_range(0, 7))
        0: flip = 8'h01 << $urandom_range(0, 5);
        1: flip = 8'h40 << $urandom_range(0, 1);
        default: flip = 8'h00;
      endcase
      make_hdr(2'($urandom), dt, wc, flip);
      nw = 0;
      if (dt >= 6'h10) begin
        nw = (int'(wc) + 1) / 2;
        for (int j = 0; j < nw; j++) burst_w.push_back(16'($urandom));
        burst_w.push_back(16'($urandom));
      end
      n_sent = burst_w.size();
      if (nw > 0 && $urandom_range(0, 3) == 0) n_sent = 2 + int'($urandom_range(0, nw - 1));
      run_burst(n_sent);
      expect_burst(n_sent);
    end

    // Reset asserted mid-payload
    make_hdr(2'd0, 6'h2A, 16'd8, 8'h00);
    for (int j = 0; j < 5; j++) burst_w.push_back(16'h7700 + 16'(j));
    for (int i = 0; i < 3; i++) begin
      bus.dl0_rxvalidhs = 1'b1;
      bus.dl1_rxvalidhs = 1'b1;
      bus.word_valid    = 1'b1;
      bus.word_in       = burst_w[i];
      @(negedge clk);
    end
    chk("pre_rst_pay", 32'(bus.pay_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pay", 32'(bus.pay_valid), 32'd0);
    chk("mid_rst_arn", 32'(bus.align_resetn), 32'd0);
    chk("mid_rst_line", 32'(bus.line_count), 32'd0);
    chk("mid_rst_frame", 32'(bus.frame_active), 32'd0);
    chk("mid_rst_dt", 32'(bus.pkt_dt), 32'd0);
    drive_idle();
    m_frame = 1'b0; m_line = '0; m_vc = '0; m_dt = '0; m_wc = '0; m_short = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_arn_1", 32'(bus.align_resetn), 32'd0);
    @(negedge clk);
    chk("post_rst_arn_2", 32'(bus.align_resetn), 32'd1);
    make_hdr(2'd2, 6'h00, 16'h0003, 8'h00);
    run_burst(2);
    expect_burst(2);

    chk("keep_last_idle", 32'(idle_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
